// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game slice: score width, BCD limit and
// the score_keeper state encoding.
package flappy_pkg;

  localparam int SCORE_W = 16;

  // Default saturation value of the 4-digit BCD display.
  localparam logic [SCORE_W-1:0] BCD_MAX_DEFAULT = 16'h9999;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

endpackage

// File: rtl/score_keeper_bcd4_inc.sv
// bcd4_inc: combinational +1 on a 4-digit packed BCD value with decimal
// carry. Holds at BCD_MAX and flags o_sat when the input is already there.
module bcd4_inc
  import flappy_pkg::*;
#(
  parameter logic [SCORE_W-1:0] BCD_MAX = BCD_MAX_DEFAULT
) (
  input  logic [SCORE_W-1:0] i_bcd,
  output logic [SCORE_W-1:0] o_bcd,
  output logic               o_sat
);

  logic [SCORE_W-1:0] w_inc;

  // Ripple the increment up through the digits, then clamp at BCD_MAX.
  always_comb begin
    logic w_all9;
    w_inc  = i_bcd;
    w_all9 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_all9) begin
        if (i_bcd[4*i +: 4] >= 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = i_bcd[4*i +: 4] + 4'd1;
        end
      end else begin
        w_inc[4*i +: 4] = i_bcd[4*i +: 4];
      end
      w_all9 = w_all9 & (i_bcd[4*i +: 4] == 4'd9);
    end
    o_sat = (i_bcd >= BCD_MAX);
    if (o_sat) begin
      o_bcd = BCD_MAX;
    end else begin
      o_bcd = w_inc;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: follows the game controller's score one point per tick on a
// 4-digit BCD display, settles it on game over, and blinks while over.
// Optional feature macro SCORE_KEEPER_BEST_EN adds best-score tracking
// (best_bcd, new_record, clr_best); without it those outputs read 0.
module score_keeper
  import flappy_pkg::*;
#(
  parameter int unsigned        BLINK_HALF = 5,
  parameter logic [SCORE_W-1:0] BCD_MAX    = BCD_MAX_DEFAULT
) (
  input  logic               clk_100ms,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               fail_in,
  input  logic               clr_best,
  output logic [SCORE_W-1:0] disp_bcd,
  output logic [SCORE_W-1:0] best_bcd,
  output logic               new_record,
  output logic               ovf,
  output logic               blink,
  output logic [1:0]         state
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SCORE_W-1:0] r_disp_bin;
  logic [SCORE_W-1:0] r_disp_bcd;
  logic               r_ovf;
  logic               r_blink;
  logic [CNT_W-1:0]   r_blink_cnt;

  logic [SCORE_W-1:0] w_disp_bin_nxt;
  logic [SCORE_W-1:0] w_disp_bcd_nxt;
  logic               w_ovf_nxt;
  logic [SCORE_W-1:0] w_inc_bcd;
  logic               w_inc_sat;
  logic               w_eq;
  logic               w_settle_to_over;
  logic               w_enter_play;

  bcd4_inc #(.BCD_MAX(BCD_MAX)) u_inc (
    .i_bcd (r_disp_bcd),
    .o_bcd (w_inc_bcd),
    .o_sat (w_inc_sat)
  );

  assign w_eq             = (r_disp_bin == score_in);
  assign w_settle_to_over = (r_state == ST_SETTLE) && (w_state_nxt == ST_OVER);
  assign w_enter_play     = (r_state != ST_PLAY) && (w_state_nxt == ST_PLAY);

  // Display step: chase score_in by one point, or drop to zero on regression.
  always_comb begin
    w_disp_bin_nxt = r_disp_bin;
    w_disp_bcd_nxt = r_disp_bcd;
    w_ovf_nxt      = r_ovf;
    if (r_disp_bin < score_in) begin
      w_disp_bin_nxt = r_disp_bin + 16'd1;
      w_disp_bcd_nxt = w_inc_bcd;
      w_ovf_nxt      = r_ovf | w_inc_sat;
    end else if (r_disp_bin > score_in) begin
      w_disp_bin_nxt = 16'd0;
      w_disp_bcd_nxt = 16'd0;
      w_ovf_nxt      = 1'b0;
    end else begin
      w_disp_bin_nxt = r_disp_bin;
      w_disp_bcd_nxt = r_disp_bcd;
      w_ovf_nxt      = r_ovf;
    end
  end

  // Display registers.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_disp_bin <= 16'd0;
      r_disp_bcd <= 16'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_disp_bin <= w_disp_bin_nxt;
      r_disp_bcd <= w_disp_bcd_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Game-phase next state; SETTLE waits for the display to catch up.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PLAY: begin
        if (fail_in) w_state_nxt = ST_SETTLE;
        else         w_state_nxt = ST_PLAY;
      end
      ST_SETTLE: begin
        if (!fail_in)  w_state_nxt = ST_PLAY;
        else if (w_eq) w_state_nxt = ST_OVER;
        else           w_state_nxt = ST_SETTLE;
      end
      ST_OVER: begin
        if (!fail_in) w_state_nxt = ST_PLAY;
        else          w_state_nxt = ST_OVER;
      end
      default: w_state_nxt = ST_PLAY;
    endcase
  end

  // Game-phase state register.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) r_state <= ST_PLAY;
    else      r_state <= w_state_nxt;
  end

  // Blink divider: restarts on OVER entry, toggles every BLINK_HALF ticks.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if ((w_state_nxt == ST_OVER) && (r_state == ST_OVER)) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end
  end

`ifdef SCORE_KEEPER_BEST_EN
  // The best score must survive rst, so these registers have no reset and
  // start from their declared initial value.
  logic [SCORE_W-1:0] r_best_bin = {SCORE_W{1'b0}};
  logic [SCORE_W-1:0] r_best_bcd = {SCORE_W{1'b0}};
  logic               r_new_record;

  // Best score: latched on settle completion; an explicit clear wins.
  always_ff @(posedge clk_100ms) begin
    if (clr_best) begin
      r_best_bin <= 16'd0;
      r_best_bcd <= 16'd0;
    end else if (w_settle_to_over && (r_disp_bin > r_best_bin)) begin
      r_best_bin <= r_disp_bin;
      r_best_bcd <= r_disp_bcd;
    end else begin
      r_best_bin <= r_best_bin;
      r_best_bcd <= r_best_bcd;
    end
  end

  // Record flag: decided at settle completion, dropped when play resumes.
  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_new_record <= 1'b0;
    end else if (w_settle_to_over) begin
      r_new_record <= (r_disp_bin > r_best_bin);
    end else if (w_enter_play) begin
      r_new_record <= 1'b0;
    end else begin
      r_new_record <= r_new_record;
    end
  end

  assign best_bcd   = r_best_bcd;
  assign new_record = r_new_record;
`else
  logic w_unused_best;
  assign w_unused_best = clr_best ^ w_settle_to_over ^ w_enter_play;
  assign best_bcd      = 16'd0;
  assign new_record    = 1'b0;
`endif

  assign disp_bcd = r_disp_bcd;
  assign ovf      = r_ovf;
  assign blink    = r_blink;
  assign state    = r_state;

endmodule

// File: doc/score_keeper.md
# score_keeper

Downstream consumer of the game controller's `score` and `fail` outputs. Runs on the same 100 ms game tick. Produces a 4-digit BCD score for the seven-segment display that counts up one point per tick toward the controller's score. On game over it settles the display, latches the best score, and drives a blink enable for the display driver.

## Interface
Parameters:
- `BLINK_HALF`, default 5: game-over blink half-period in ticks (5 → 500 ms).
- `BCD_MAX`, default 16'h9999: BCD saturation value.

Ports:
- `clk_100ms`  in  1: game tick clock.
- `rst`  in  1: asynchronous, active-low reset.
- `score_in`  in  16: binary score from the game controller.
- `fail_in`  in  1: game-over flag from the game controller.
- `clr_best`  in  1: synchronous clear of the best score. Level-sampled.
- `disp_bcd`  out  16: displayed score, 4 BCD digits, MSD in [15:12].
- `best_bcd`  out  16: best score, BCD.
- `new_record`  out  1: last finished game set a new best.
- `ovf`  out  1: displayed count exceeded 9999; `disp_bcd` is saturated.
- `blink`  out  1: display blank request, toggling in OVER.
- `state`  out  2: 0 = PLAY, 1 = SETTLE, 2 = OVER.

## Operation
- Internal `disp_bin` (16 bit) tracks `disp_bcd`.
- Every tick, in any state:
  - `disp_bin < score_in`: `disp_bin += 1`. `disp_bcd` increments with decimal carry, or holds at `BCD_MAX`. Once saturated, `ovf` is 1.
  - `disp_bin > score_in`: score regressed. `disp_bin`, `disp_bcd` and `ovf` clear to 0.
  - Equal: hold.
- The display advances at most one point per tick. A +2 jump takes two ticks to show.
- State machine:
  - PLAY → SETTLE when `fail_in` = 1.
  - SETTLE → OVER when `disp_bin == score_in` (evaluated with the current-tick values). If equal already on the fail tick, PLAY → SETTLE → OVER takes 2 ticks.
  - OVER → PLAY when `fail_in` = 0. Not reachable without `rst` in the current controller.
  - SETTLE → PLAY if `fail_in` drops.
- Best update, on the SETTLE → OVER transition tick only:
  - If `disp_bin > best_bin`: `best_bin` ← `disp_bin`, `best_bcd` ← `disp_bcd`, `new_record` ← 1.
  - Otherwise `new_record` ← 0.
- `new_record` clears on re-entry to PLAY.
- Blink: the counter resets when OVER is entered, and `blink` toggles every `BLINK_HALF` ticks while in OVER. In PLAY and SETTLE, `blink` = 0.
- `clr_best` = 1 zeroes `best_bin` and `best_bcd` on the next tick. If it coincides with a best update, the clear wins.

## Timing
- All outputs are registered. `disp_bcd` reflects a `score_in` step one tick after the controller registers it.
- `rst` low forces asynchronously:
  - `state` = PLAY
  - `disp_bcd` = 0, `disp_bin` = 0
  - `ovf` = 0, `blink` = 0, `new_record` = 0
- `best_bin` and `best_bcd` are not affected by `rst`, so the best survives game restarts. Their power-up value is 0 via register initialisation. `clr_best` is their only clear.
- A reset mid-SETTLE abandons the best update.

## Configuration
- `SCORE_KEEPER_BEST_EN` defined: best tracking, `best_bcd`, `new_record` and `clr_best` are implemented as described.
- Not defined:
  - `best_bcd` is tied to 0 and `new_record` to 0.
  - `clr_best` is ignored.
  - The best registers are not instantiated.
  - The state machine and display path are unchanged.

## Structure
- Shared package `flappy_pkg` holds:
  - State encodings `ST_PLAY`, `ST_SETTLE`, `ST_OVER`.
  - `BCD_MAX` default.
  - Score width constant `SCORE_W` = 16.
- One sub-module, `bcd4_inc`: combinational 4-digit BCD +1 with decimal carry and saturation at `BCD_MAX`. It outputs the next value and a saturated flag.

## Test plan
- Reset, then `score_in` 0 → 1 → 2 on consecutive ticks → `disp_bcd` = 0001 then 0002, each one tick after the input step.
- `score_in` jumps 0 → 3 in one tick → `disp_bcd` = 0001, 0002, 0003 over three ticks, then holds.
- `disp_bcd` at 0009 with `score_in` = 10 → 0010 (decimal carry). Force `score_in` = 10005 from 9999 → `disp_bcd` holds 9999 and `ovf` = 1.
- `fail_in` = 1 while `score_in` = 7 and display = 5 → SETTLE for two ticks, then OVER with `best_bcd` = 0007 and `new_record` = 1. `blink` toggles every 5 ticks after OVER entry.
- Pulse `rst`, replay to a score of 4 and fail → `best_bcd` stays 0007 and `new_record` = 0. Assert `clr_best` → `best_bcd` = 0000 next tick.
- `rst` low during SETTLE → `state` = PLAY, `disp_bcd` = 0 immediately, `best_bcd` unchanged.
